rom_image_writer: RTL and testbench

- Write-side counterpart to the team's 16x8 lookup ROMs: a writable 16-word x 8-bit table loaded by burst over a valid/ready byte stream.
- A small FSM takes a start address and a word count, then accepts bytes and writes them into consecutive addresses, wrapping at the top.
- The read side keeps the same look-up style as the ROMs: combinational data for an address with an enable.
- Sits between a loader (UART or testbench byte source) and datapath logic that used to read hard-coded ROM contents.

---
 rtl/rom_image_writer_if.sv | 40 ++++
 rtl/rom_image_writer.sv | 78 +++++++
 tb/tb_rom_image_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_image_writer_if.sv
// rom_image_writer_if: burst-load and look-up bus of the 16x8 writable table.
// With ROM_IMAGE_WRITER_PARITY_EN defined it also carries inj_perr/rd_perr.
interface rom_image_writer_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] count;
    logic          abort;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
`ifdef ROM_IMAGE_WRITER_PARITY_EN
    logic          inj_perr;
    logic          rd_perr;
    modport master (
        output start, base_addr, count, abort, wr_valid, wr_data, rd_en, rd_addr, inj_perr,
        input  wr_ready, busy, done, rd_data, rd_perr
    );
    modport slave (
        input  start, base_addr, count, abort, wr_valid, wr_data, rd_en, rd_addr, inj_perr,
        output wr_ready, busy, done, rd_data, rd_perr
    );
`else
    modport master (
        output start, base_addr, count, abort, wr_valid, wr_data, rd_en, rd_addr,
        input  wr_ready, busy, done, rd_data
    );
    modport slave (
        input  start, base_addr, count, abort, wr_valid, wr_data, rd_en, rd_addr,
        output wr_ready, busy, done, rd_data
    );
`endif
endinterface

// File: rtl/rom_image_writer.sv
// rom_image_writer: 16x8 table loaded by valid/ready burst, read combinationally.
// Optional per-word even parity with ROM_IMAGE_WRITER_PARITY_EN.
module rom_image_writer #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input logic clk,
    input logic rst,
    rom_image_writer_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          we;
`ifdef ROM_IMAGE_WRITER_PARITY_EN
    logic [DEPTH-1:0] par_q;
`endif
    // Burst sequencing: abort beats a simultaneous handshake so that byte is dropped
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = WRITE;
                    ptr_d   = bus.base_addr;
                    rem_d   = bus.count;
                end
            end
            WRITE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.wr_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (rem_q == '0) state_d = DONE;
                    else rem_d = rem_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // State, pointer, remaining count and table storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef ROM_IMAGE_WRITER_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            if (we) begin
                mem_q[ptr_q] <= bus.wr_data;
`ifdef ROM_IMAGE_WRITER_PARITY_EN
                par_q[ptr_q] <= ^bus.wr_data ^ bus.inj_perr;
`endif
            end
        end
    end
    assign bus.wr_ready = (state_q == WRITE);
    assign bus.busy     = (state_q == WRITE);
    assign bus.done     = (state_q == DONE);
    assign bus.rd_data  = bus.rd_en ? mem_q[bus.rd_addr] : '0;
`ifdef ROM_IMAGE_WRITER_PARITY_EN
    assign bus.rd_perr  = bus.rd_en & (par_q[bus.rd_addr] != ^mem_q[bus.rd_addr]);
`endif
endmodule

// File: tb/tb_rom_image_writer.sv
// tb_rom_image_writer: directed bursts with a queued scoreboard for reads/status and done pulses.
module tb_rom_image_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_image_writer_if #(.DW(8), .AW(4)) bus ();
    rom_image_writer #(.DW(8), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] rd;
        logic [2:0] st;
        logic       pe;
    } exp_t;

    exp_t       rq[$];
    int         dq[$];
    exp_t       me;
    int         dc;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] em [16];
    logic [7:0] bb [16];
    logic       act_pe;

`ifdef ROM_IMAGE_WRITER_PARITY_EN
    assign act_pe = bus.rd_perr;
`else
    assign act_pe = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare queued read/status expectations and done pulses mid-cycle
    always @(negedge clk) begin
        while (rq.size() > 0 && rq[0].cyc <= cyc) begin
            me = rq.pop_front();
            tests++;
            if (me.cyc != cyc) begin
                fails++;
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", me.name, me.cyc, cyc);
            end else if (bus.rd_data !== me.rd || {bus.wr_ready, bus.busy, bus.done} !== me.st || act_pe !== me.pe) begin
                fails++;
                $display("FAIL %s @%0d addr=%h: got rd_data=%h rdy/busy/done=%b perr=%b, want rd_data=%h rdy/busy/done=%b perr=%b",
                         me.name, cyc, bus.rd_addr, bus.rd_data, {bus.wr_ready, bus.busy, bus.done}, act_pe, me.rd, me.st, me.pe);
            end
        end
        if (bus.done) begin
            tests++;
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL done_pulse: unexpected done at cycle %0d, want none", cyc);
            end else begin
                dc = dq.pop_front();
                if (dc != cyc) begin
                    fails++;
                    $display("FAIL done_pulse: done at cycle %0d, want cycle %0d", cyc, dc);
                end
            end
        end else if (dq.size() > 0 && dq[0] <= cyc) begin
            tests++;
            fails++;
            dc = dq.pop_front();
            $display("FAIL done_pulse: done=0 at cycle %0d, want 1 at cycle %0d", cyc, dc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string name, input logic en, input logic [3:0] a,
                             input logic [7:0] d, input logic [2:0] st, input logic pe);
        bus.rd_en   = en;
        bus.rd_addr = a;
        rq.push_back('{cyc, name, d, st, pe});
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < 16; a++) begin
            expect_rd(name, 1'b1, 4'(a), em[a], 3'b000, 1'b0);
            tick();
        end
    endtask

    task automatic burst(input logic [3:0] base, input logic [3:0] cnt);
        logic [3:0] a;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = cnt;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= int'(cnt); i++) begin
            a            = base + 4'(i);
            em[a]        = bb[i];
            bus.wr_valid = 1'b1;
            bus.wr_data  = bb[i];
            tick();
        end
        bus.wr_valid = 1'b0;
        dq.push_back(cyc);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        bus.abort     = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
`ifdef ROM_IMAGE_WRITER_PARITY_EN
        bus.inj_perr  = 1'b0;
`endif
        for (int i = 0; i < 16; i++) em[i] = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        sweep("reset_sweep");

        bb[0] = 8'hA9; bb[1] = 8'hFD; bb[2] = 8'hE9;
        burst(4'h3, 4'h2);
        expect_rd("burst3_done", 1'b1, 4'h5, 8'hE9, 3'b001, 1'b0);
        tick();
        sweep("burst3_sweep");

        bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33; bb[3] = 8'h44;
        burst(4'hE, 4'h3);
        expect_rd("wrap_done", 1'b1, 4'hE, 8'h11, 3'b001, 1'b0);
        tick();
        expect_rd("wrap_F", 1'b1, 4'hF, 8'h22, 3'b000, 1'b0); tick();
        expect_rd("wrap_0", 1'b1, 4'h0, 8'h33, 3'b000, 1'b0); tick();
        expect_rd("wrap_1", 1'b1, 4'h1, 8'h44, 3'b000, 1'b0); tick();
        expect_rd("wrap_2", 1'b1, 4'h2, 8'h00, 3'b000, 1'b0); tick();

        bus.start = 1'b1; bus.base_addr = 4'h8; bus.count = 4'h3;
        tick();
        bus.start = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h55; em[8] = 8'h55;
        tick();
        bus.wr_valid = 1'b0;
        expect_rd("abort_stall", 1'b1, 4'h9, 8'h00, 3'b110, 1'b0);
        tick();
        bus.wr_valid = 1'b1; bus.wr_data = 8'h66; em[9] = 8'h66;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        bus.wr_valid = 1'b1; bus.wr_data = 8'h77; bus.abort = 1'b1;
        expect_rd("abort_cycle", 1'b1, 4'h9, 8'h66, 3'b110, 1'b0);
        tick();
        bus.wr_valid = 1'b0; bus.abort = 1'b0;
        expect_rd("abort_idle", 1'b1, 4'hA, 8'h00, 3'b000, 1'b0);
        bus.start = 1'b1; bus.base_addr = 4'hC; bus.count = 4'h0;
        tick();
        bus.start = 1'b0;
        expect_rd("restart_busy", 1'b1, 4'hA, 8'h00, 3'b110, 1'b0);
        bus.wr_valid = 1'b1; bus.wr_data = 8'h5A; em[12] = 8'h5A;
        tick();
        bus.wr_valid = 1'b0;
        dq.push_back(cyc);
        expect_rd("restart_done", 1'b1, 4'hC, 8'h5A, 3'b001, 1'b0);
        tick();
        sweep("abort_sweep");

        bus.start = 1'b1; bus.base_addr = 4'h5; bus.count = 4'h0;
        tick();
        bus.start = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 8'hC3;
        expect_rd("rd_old", 1'b1, 4'h5, 8'hE9, 3'b110, 1'b0);
        tick();
        bus.wr_valid = 1'b0;
        em[5] = 8'hC3;
        dq.push_back(cyc);
        expect_rd("rd_new", 1'b1, 4'h5, 8'hC3, 3'b001, 1'b0);
        tick();
        expect_rd("rd_disabled", 1'b0, 4'h5, 8'h00, 3'b000, 1'b0);
        tick();

`ifdef ROM_IMAGE_WRITER_PARITY_EN
        bb[0] = 8'h3C;
        bus.inj_perr = 1'b1;
        burst(4'h7, 4'h0);
        bus.inj_perr = 1'b0;
        expect_rd("perr_bad", 1'b1, 4'h7, 8'h3C, 3'b001, 1'b1);
        tick();
        expect_rd("perr_zero", 1'b1, 4'h6, 8'h00, 3'b000, 1'b0); tick();
        expect_rd("perr_ok", 1'b1, 4'h3, 8'hA9, 3'b000, 1'b0); tick();
        expect_rd("perr_off", 1'b0, 4'h7, 8'h00, 3'b000, 1'b0); tick();
`endif

        bus.start = 1'b1; bus.base_addr = 4'h0; bus.count = 4'h7;
        tick();
        bus.start = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h99;
        tick();
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) em[i] = 8'h00;
        sweep("midreset_sweep");

        tick();
        tick();
        tests++;
        if (dq.size() != 0 || rq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d done and %0d read expectations left, want 0 and 0", dq.size(), rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
